data_mem_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 is the core

---
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-port data memory.
// Port 0 is the core load/store unit, port 1 the debug/DMA loader. After reset
// or a clr pulse the block walks the memory writing zeros, one word per cycle,
// before serving any request.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin on conflicts;
// when undefined, port 0 has fixed priority).
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    // Counter is sized to exactly hold 0..MEM_SIZE-1; the last-word compare uses
    // a constant of the same width so a power-of-2 MEM_SIZE cannot overflow it.
    localparam int CW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_SIZE - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          run;
    logic          sel1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last port that won a conflict; the other port wins the next one.
    logic ptr;

    // Grant select: on a conflict the port that did not win last time goes.
    always_comb begin
        sel1 = p1_req & (~p0_req | ~ptr);
    end

    // Pointer moves only when both ports competed in RUN.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (run && p0_req && p1_req)
            ptr <= sel1;
    end
`else
    // Grant select: port 0 always wins a conflict.
    always_comb begin
        sel1 = p1_req & ~p0_req;
    end
`endif

    assign run    = (state == S_RUN);
    assign busy   = ~run;
    assign p0_gnt = run & p0_req & ~sel1;
    assign p1_gnt = run & sel1;

    // Memory pin mux: clear writes while busy, otherwise the granted port.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (!run) begin
            mem_we   = 1'b1;
            mem_addr = ADDR_WIDTH'(cnt);
        end else if (p0_gnt) begin
            mem_we   = p0_we;
            mem_addr = p0_addr;
            mem_data = p0_wdata;
        end else if (p1_gnt) begin
            mem_we   = p1_we;
            mem_addr = p1_addr;
            mem_data = p1_wdata;
        end
    end

    // Clear sequencer: rst/clr restart at word 0; leave for RUN after the last word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            if (cnt == LAST) begin
                state <= S_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Read return: capture mem_q at the end of a read grant; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_q;
            if (p1_gnt && !p1_we) p1_rdata <= mem_q;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed steps plus random traffic checked
// against a word-level model of the memory and the arbitration rules.
module tb_data_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          rst, clr, busy;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_we;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    // The physical memory the arbiter drives: combinational read, posedge write.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) dev_mem[mem_addr] <= mem_data;
    assign mem_q = dev_mem[mem_addr];

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_rd0, ref_rd1;
    bit            ref_last;  // port that won the previous conflict
    int            n_chk  = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One RUN cycle with given requests; entered and left at posedge+1.
    task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit c);
        bit g0, g1;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        clr = c;
        if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            g1 = (ref_last == 1'b0);
`else
            g1 = 1'b0;
`endif
            g0 = !g1;
            ref_last = g1;
        end else begin
            g0 = r0; g1 = r1;
        end
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (g0) begin e_we = w0; e_addr = a0; e_data = d0; end
        if (g1) begin e_we = w1; e_addr = a1; e_data = d1; end
        #2;
        chk("busy_run", busy, 0);
        chk("p0_gnt", p0_gnt, g0);
        chk("p1_gnt", p1_gnt, g1);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data", mem_data, e_data);
        if (g0 && !w0) ref_rd0 = ref_mem[a0];
        if (g1 && !w1) ref_rd1 = ref_mem[a1];
        if (e_we) ref_mem[e_addr] = e_data;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("p0_rvalid", p0_rvalid, g0 && !w0);
        chk("p1_rvalid", p1_rvalid, g1 && !w1);
        chk("p0_rdata", p0_rdata, ref_rd0);
        chk("p1_rdata", p1_rdata, ref_rd1);
    endtask

    // One clear cycle expected to write word i; requests held to prove stalling.
    task automatic clear_step(input int i, input bit r, input bit c);
        p0_req = 1'b1; p1_req = 1'b1;
        rst = r; clr = c;
        #2;
        chk("clr_busy", busy, 1);
        chk("clr_we", mem_we, 1);
        chk("clr_addr", mem_addr, i);
        chk("clr_data", mem_data, 0);
        chk("clr_gnt0", p0_gnt, 0);
        chk("clr_gnt1", p1_gnt, 0);
        @(posedge clk); #1;
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic clear_part(input int n);
        for (int i = 0; i < n; i++) clear_step(i, 1'b0, 1'b0);
    endtask

    task automatic clear_full();
        clear_part(MS);
        for (int i = 0; i < MS; i++) ref_mem[i] = '0;
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int k = $urandom_range(0, 9);
        if (k < 5) return AW'($urandom_range(0, 7));
        if (k < 9) return AW'($urandom_range(0, MS-1));
        return AW'($urandom_range(MS, 2*MS-1));
    endfunction

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ref_rd0 = '0; ref_rd1 = '0; ref_last = 1'b0;
        rst = 1'b1; clr = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset values, sampled while rst is still asserted.
        @(posedge clk); #3;
        chk("rst_busy", busy, 1);
        chk("rst_gnt0", p0_gnt, 0);
        chk("rst_gnt1", p1_gnt, 0);
        chk("rst_rvalid0", p0_rvalid, 0);
        chk("rst_rvalid1", p1_rvalid, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_rdata1", p1_rdata, 0);
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full clear after reset release.
        clear_full();

        // Write then read back on port 0.
        step(1, 1, 16'h0005, 16'hBEEF, 0, 0, 0, 0, 0);
        step(1, 0, 16'h0005, 16'h0000, 0, 0, 0, 0, 0);

        // Six cycles of continuous conflict.
        repeat (6) step(1, 0, rnd_addr(), 0, 1, 0, rnd_addr(), 0, 0);

        // Port 1 alone.
        step(0, 0, 0, 0, 1, 0, 16'h0010, 0, 0);

        // Random traffic.
        repeat (300)
            step($urandom_range(0,1), $urandom_range(0,1), rnd_addr(), DW'($urandom),
                 $urandom_range(0,1), $urandom_range(0,1), rnd_addr(), DW'($urandom), 0);

        // Write, then clr coinciding with a read grant (grant honoured),
        // clr again mid-clear, then the cleared word reads as zero.
        step(0, 0, 0, 0, 1, 1, 16'h0020, 16'h1234, 0);
        step(1, 0, 16'h0020, 0, 0, 0, 0, 0, 1);
        clear_part(100);
        clear_step(100, 1'b0, 1'b1);
        clear_full();
        step(1, 0, 16'h0020, 0, 0, 0, 0, 0, 0);

        // rst at clear count 300 restarts the full clear and the pointer.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        clear_part(300);
        clear_step(300, 1'b1, 1'b0);
        ref_rd0 = '0; ref_rd1 = '0; ref_last = 1'b0;
        clear_full();
        repeat (4) step(1, 0, rnd_addr(), 0, 1, 0, rnd_addr(), 0, 0);

        // More random traffic after the reset.
        repeat (100)
            step($urandom_range(0,1), $urandom_range(0,1), rnd_addr(), DW'($urandom),
                 $urandom_range(0,1), $urandom_range(0,1), rnd_addr(), DW'($urandom), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
